// File: rtl/mult4_seq_if.sv
// Handshake and operand/result bundle for the sequential 4x4 multiplier.
// The master side issues operations and the slave side (the multiplier) answers.
interface mult4_seq_if;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mult4_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier.
// One 4-bit ripple-carry adder is reused for one partial-product addition per cycle.

module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[4];
endmodule

module mult4_seq (
    input  logic          clk,
    input  logic          rst_n,
    mult4_seq_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] mcand_q, mcand_d;
    // The carry bit above acc[7] is always zero after a shift, so only 8 bits are stored.
    logic [7:0] acc_q, acc_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] product_q, product_d;

    logic [3:0] sum;
    logic       c_out;

    adder4 u_adder (
        .a    (acc_q[7:4]),
        .b    (mcand_q),
        .cin  (1'b0),
        .sum  (sum),
        .cout (c_out)
    );

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    state_d = S_RUN;
                    mcand_d = bus.a;
                    acc_d   = {4'h0, bus.b};
                    cnt_d   = 2'd0;
                end
            end
            S_RUN: begin
                // Add the multiplicand into the high half when the current multiplier bit is set.
                if (acc_q[0]) begin
                    acc_d = {c_out, sum, acc_q[3:1]};
                end else begin
                    acc_d = {1'b0, acc_q[7:4], acc_q[3:1]};
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    product_d = acc_d;
                    state_d   = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= 4'h0;
            acc_q     <= 8'h00;
            cnt_q     <= 2'd0;
            product_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = (state_q == S_RUN);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = product_q;
endmodule

// File: tb/tb_mult4_seq.sv
// Directed self-checking bench for mult4_seq: vector table, multi-cycle corner cases,
// and an exhaustive operand sweep against an arithmetic reference.
module tb_mult4_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mult4_seq_if bus_if ();

    mult4_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negative edge; returns at the negative edge after the done cycle.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                         input bit verbose);
        int busy_cnt;
        int t;
        busy_cnt = 0;
        t = 0;
        bus_if.a = a;
        bus_if.b = b;
        bus_if.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.a = ~a;
        bus_if.b = ~b;
        while (!bus_if.done && t < 20) begin
            if (bus_if.busy) busy_cnt++;
            @(negedge clk);
            t++;
        end
        check("latency", t, 4);
        check("busy_cycles", busy_cnt, 4);
        check("product", bus_if.product, exp);
        if (verbose)
            $display("op %0d*%0d -> product=%02h latency=%0d", a, b, bus_if.product, t);
        @(negedge clk);
        check("done_single", bus_if.done, 1'b0);
        check("product_held", bus_if.product, exp);
    endtask

    vec_t vecs[8];

    initial begin
        int done_cnt;
        int first_done;
        int second_done;
        logic [7:0] p1;
        logic [7:0] p2;
        bit stable;

        checks = 0;
        errors = 0;
        vecs[0] = '{4'd3,  4'd5,  8'h0F};
        vecs[1] = '{4'd15, 4'd15, 8'hE1};
        vecs[2] = '{4'd0,  4'd9,  8'h00};
        vecs[3] = '{4'd9,  4'd1,  8'h09};
        vecs[4] = '{4'd1,  4'd0,  8'h00};
        vecs[5] = '{4'd12, 4'd10, 8'h78};
        vecs[6] = '{4'd8,  4'd15, 8'h78};
        vecs[7] = '{4'd15, 4'd1,  8'h0F};

        rst_n = 1'b0;
        bus_if.start = 1'b0;
        bus_if.a = 4'h0;
        bus_if.b = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", bus_if.busy, 1'b0);
        check("reset_done", bus_if.done, 1'b0);
        check("reset_product", bus_if.product, 8'h00);
        $display("reset: busy=%0b done=%0b product=%02h", bus_if.busy, bus_if.done, bus_if.product);
        rst_n = 1'b1;

        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.product !== 8'h00)
                stable = 1'b0;
        end
        check("idle_stable", stable, 1'b1);
        $display("idle: 10 cycles, stable=%0b", stable);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
            repeat (2) @(negedge clk);
            check("hold_in_idle", bus_if.product, vecs[i].exp);
        end

        // Second start arrives mid-run and must be ignored.
        bus_if.a = 4'd7;
        bus_if.b = 4'd6;
        bus_if.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        @(negedge clk);
        bus_if.a = 4'd2;
        bus_if.b = 4'd2;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus_if.done) begin
                done_cnt++;
                check("ignore_busy_product", bus_if.product, 8'h2A);
            end
            @(negedge clk);
        end
        check("ignore_busy_done_count", done_cnt, 1);
        $display("ignore-while-busy: 7*6 product=%02h dones=%0d", bus_if.product, done_cnt);

        // Back-to-back with start held high; second operands presented in the DONE cycle.
        bus_if.a = 4'd4;
        bus_if.b = 4'd4;
        bus_if.start = 1'b1;
        done_cnt = 0;
        first_done = -1;
        second_done = -1;
        p1 = 8'h00;
        p2 = 8'h00;
        @(posedge clk);
        for (int c = 0; c < 20 && done_cnt < 2; c++) begin
            @(negedge clk);
            if (bus_if.done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    first_done = c;
                    p1 = bus_if.product;
                    bus_if.a = 4'd13;
                    bus_if.b = 4'd11;
                end else begin
                    second_done = c;
                    p2 = bus_if.product;
                    bus_if.start = 1'b0;
                end
            end
        end
        bus_if.start = 1'b0;
        check("b2b_done_count", done_cnt, 2);
        check("b2b_spacing", second_done - first_done, 5);
        check("b2b_product1", p1, 8'h10);
        check("b2b_product2", p2, 8'h8F);
        $display("back-to-back: 4*4=%02h 13*11=%02h spacing=%0d", p1, p2, second_done - first_done);
        repeat (2) @(negedge clk);

        // Reset asserted mid-operation.
        bus_if.a = 4'd15;
        bus_if.b = 4'd15;
        bus_if.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", bus_if.busy, 1'b0);
        check("midreset_done", bus_if.done, 1'b0);
        check("midreset_product", bus_if.product, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_if.done) done_cnt++;
        end
        check("midreset_no_done", done_cnt, 0);
        $display("mid-op reset: product=%02h dones after release=%0d", bus_if.product, done_cnt);

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                do_op(4'(x), 4'(y), 8'(x * y), 1'b0);
            end
        end
        $display("sweep: 256 pairs applied");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mult4_seq.md
# mult4_seq

Sequential 4x4 unsigned shift-and-add multiplier built around the team's 4-bit ripple-carry adder (`adder4`). It sits directly downstream of that adder and reuses one instance for one partial-product addition per cycle. This trades latency for area compared with an array multiplier. A start/busy/done handshake frames each operation, and the 8-bit product is held stable until the next completion.

## Interface
- Parameters: none. Operand width is fixed at 4 bits to match `adder4`.
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; sampled only when `busy`=0
- `a`  in  4  multiplicand, captured when `start` is accepted
- `b`  in  4  multiplier, captured when `start` is accepted
- `busy`  out  1  high while an operation is in progress
- `done`  out  1  one-cycle pulse; `product` is valid and updated
- `product`  out  8  unsigned a*b of the last completed operation

## Operation
- Internal registers:
  - `mcand[3:0]`: the captured multiplicand.
  - `acc[8:0]`: `{carry, hi[3:0], lo[3:0]}`.
  - `cnt[1:0]`: iteration counter.
  - `state`: one of IDLE, RUN, DONE.
- Datapath: one `adder4` instance with inputs `acc[7:4]` and `mcand`, producing `sum[3:0]` and `c_out`. No other adder is permitted.
- IDLE:
  - `busy`=0 and `done`=0.
  - If `start`=1: `mcand`<=`a`, `acc`<={1'b0, 4'h0, `b`}, `cnt`<=0, go to RUN.
- RUN, each cycle:
  - If `acc[0]`=1: `acc` <= {1'b0, `c_out`, `sum`, `acc[3:1]`}.
  - Else: `acc` <= {1'b0, 1'b0, `acc[7:4]`, `acc[3:1]`}, a plain right shift.
  - `cnt`<=`cnt`+1.
  - When `cnt`=3, the final iteration: also `product`<= next `acc[7:0]`, go to DONE.
- DONE:
  - `done`=1 and `busy`=0 for exactly one cycle.
  - If `start`=1: accept a new operation exactly as in IDLE and go to RUN. Otherwise go to IDLE.
- `start` while `busy`=1 is ignored. `a` and `b` changes during RUN have no effect.
- `product` changes only on the edge that enters DONE. It is held through IDLE and through subsequent RUN cycles.
- Arithmetic: the 8-bit result is exact for all 256 operand pairs; no overflow is possible (max 15*15=225). The adder carry is the only bit shifted into `acc[7]`.
- Reset, asserted at any time including mid-RUN:
  - Immediately forces state=IDLE, `busy`=0, `done`=0, `product`=8'h00, `acc`=0, `mcand`=0, `cnt`=0.
  - An aborted operation never produces `done`.
- State encoding is 2 bits; the unused code recovers to IDLE on the next edge with outputs as in IDLE.

## Timing
- Edge E0 accepts `start`. `busy`=1 from after E0 through after E3.
- Iterations execute on E1..E4.
- After E4: `done`=1, `busy`=0, `product` valid. Latency from accepting edge to `done` is 4 cycles.
- Back-to-back throughput: one result per 5 cycles when `start` is held high. A new start is accepted on the edge ending the DONE cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `rst_n` deassertion is assumed to be synchronised externally. The first accepting edge is the first edge with `rst_n`=1.

## Test plan
- Reset then idle: `rst_n`=0 -> `busy`=0, `done`=0, `product`=8'h00. Hold `start`=0 for 10 cycles after release -> outputs unchanged.
- Basic: `a`=3, `b`=5, pulse `start` -> `busy` high 4 cycles, `done` one cycle after E4, `product`=8'h0F held until next completion. Also `a`=15, `b`=15 -> `product`=8'hE1, exercising carry into bit 7.
- Zero/identity: `a`=0, `b`=9 -> 8'h00. `a`=9, `b`=1 -> 8'h09. `a`=1, `b`=0 -> 8'h00.
- Ignore while busy: start 7*6, then pulse `start` with `a`=2, `b`=2 at E2 -> single `done`, `product`=8'h2A, no second `done`.
- Back-to-back: hold `start`=1 with 4*4 then 13*11 presented in the DONE cycle -> `done` pulses 5 cycles apart, products 8'h10 then 8'h8F.
- Reset mid-op: start 15*15, assert `rst_n`=0 after E2 -> `busy` and `done` immediately 0, `product`=8'h00, no `done` after release. Then run an exhaustive 256-pair sweep against a reference model -> all match.
